addsub_nbit: RTL and testbench

//  - N-bit two's-complement adder/subtractor; arithmetic primitive of the FIR datapath.
//  - Combinational result S = A+B (add_sub=0) or A-B (add_sub=1), valid same cycle.
//  - Registered copies of result and flags give pipelined consumers a one-cycle-latency tap.

---
 rtl/FirPkg.sv | 17 +
 rtl/full_adder.sv | 26 ++
 rtl/addsub_nbit.sv | 72 +++++++
 tb/tb_addsub_nbit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/FirPkg.sv
// ============================================================================
// Module      : FirPkg
// Description : Shared FIR datapath definitions: datapath width and the
//               matching data word type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package FirPkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : FirPkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder cell. It is the building block of the
//               ripple-carry chain in addsub_nbit.
// Ports       : a, b, cin -> s, cout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_half;

    assign w_half = a ^ b;
    assign s      = w_half ^ cin;
    assign cout   = (a & b) | (cin & w_half);

endmodule : full_adder

`default_nettype wire

// File: rtl/addsub_nbit.sv
// ============================================================================
// Module      : addsub_nbit
// Description : N-bit two's-complement adder/subtractor.
//               The combinational outputs S/C/V are valid in the same cycle.
//               The registered copies S_q/C_q/V_q have one cycle of latency.
// Ports       : clk_i   - clock, registers update on the rising edge
//               rst_ni  - asynchronous active-low reset of the registers only
//               A, B    - operands
//               add_sub - 0 = A+B, 1 = A-B
//               S, C, V - combinational sum, carry (no-borrow on sub), overflow
//               S_q, C_q, V_q - registered copies of S, C, V
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_nbit
    import FirPkg::*;
#(
    parameter int DATA_WIDTH = FirPkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  add_sub,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  C,
    output logic                  V,
    output logic [DATA_WIDTH-1:0] S_q,
    output logic                  C_q,
    output logic                  V_q
);

    // Subtraction is A + ~B + 1. The +1 enters as the carry-in of bit 0.
    logic [DATA_WIDTH-1:0] w_bb;
    logic [DATA_WIDTH:0]   w_carry;

    assign w_bb       = B ^ {DATA_WIDTH{add_sub}};
    assign w_carry[0] = add_sub;

    generate
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ripple
            full_adder u_fa (
                .a    (A[i]),
                .b    (w_bb[i]),
                .cin  (w_carry[i]),
                .s    (S[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    assign C = w_carry[DATA_WIDTH];
    // Signed overflow occurs when the carry into the sign bit differs from
    // the carry out of the sign bit.
    assign V = w_carry[DATA_WIDTH] ^ w_carry[DATA_WIDTH-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            S_q <= '0;
            C_q <= 1'b0;
            V_q <= 1'b0;
        end else begin
            S_q <= S;
            C_q <= C;
            V_q <= V;
        end
    end

endmodule : addsub_nbit

`default_nettype wire

// File: tb/tb_addsub_nbit.sv
// ============================================================================
// Module      : tb_addsub_nbit
// Description : Self-checking bench for addsub_nbit. Random add and subtract
//               results are compared against a plain-arithmetic model. The
//               bench also covers corners, reset, async reset and latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_nbit;
    import FirPkg::*;

    logic  clk_i;
    logic  rst_ni;
    data_t A, B;
    logic  add_sub;
    data_t S, S_q;
    logic  C, V, C_q, V_q;

    int total;
    int bad;

    addsub_nbit #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .A       (A),
        .B       (B),
        .add_sub (add_sub),
        .S       (S),
        .C       (C),
        .V       (V),
        .S_q     (S_q),
        .C_q     (C_q),
        .V_q     (V_q)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: integer arithmetic on 64-bit values.
    function automatic void model(input logic op, input data_t a, input data_t b,
                                  output data_t s, output logic c, output logic v);
        longint ua, ub, sa, sb, r;
        longint maxv, minv;
        ua   = longint'({32'd0, a});
        ub   = longint'({32'd0, b});
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = (64'sd1 <<< (DATA_WIDTH - 1)) - 1;
        minv = -(64'sd1 <<< (DATA_WIDTH - 1));
        if (!op) begin
            s = data_t'(ua + ub);
            c = (ua + ub) > longint'({32'd0, {DATA_WIDTH{1'b1}}});
            r = sa + sb;
        end else begin
            s = data_t'(ua - ub);
            c = (ua >= ub);
            r = sa - sb;
        end
        v = (r > maxv) || (r < minv);
    endfunction

    task automatic test_reset();
        rst_ni  = 1'b0;
        A       = 32'd5;
        B       = 32'd3;
        add_sub = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if (S !== 32'd8) begin
            bad++; $display("FAIL reset_comb_S got=%h exp=%h", S, 32'd8);
        end
        total++;
        if ({S_q, C_q, V_q} !== {32'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_regs got=%h/%b/%b exp=0/0/0", S_q, C_q, V_q);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        total++;
        if (S_q !== 32'd0) begin
            bad++; $display("FAIL reset_hold_until_edge got=%h exp=0", S_q);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (S_q !== 32'd8) begin
            bad++; $display("FAIL reset_first_capture got=%h exp=%h", S_q, 32'd8);
        end
    endtask

    task automatic test_async_reset();
        // S_q holds 8 on entry; pull reset between edges.
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({S_q, C_q, V_q} !== {32'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL async_reset got=%h/%b/%b exp=0/0/0", S_q, C_q, V_q);
        end
        total++;
        if (S !== 32'd8) begin
            bad++; $display("FAIL async_reset_comb_S got=%h exp=%h", S, 32'd8);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_random(input logic op, input int n);
        data_t es;
        logic  ec, ev;
        add_sub = op;
        for (int i = 0; i < n; i++) begin
            A = $urandom();
            B = $urandom();
            // Bias some operands toward the sign boundaries.
            if ((i % 8) == 0) A = {1'b0, {(DATA_WIDTH-1){1'b1}}} - data_t'($urandom_range(3));
            if ((i % 8) == 1) B = {1'b1, {(DATA_WIDTH-1){1'b0}}} + data_t'($urandom_range(3));
            #1;
            model(op, A, B, es, ec, ev);
            total++;
            if ({S, C, V} !== {es, ec, ev}) begin
                bad++;
                $display("FAIL random_%s A=%h B=%h got=%h/%b/%b exp=%h/%b/%b",
                         op ? "sub" : "add", A, B, S, C, V, es, ec, ev);
            end
        end
    endtask

    task automatic test_corners();
        data_t ca [4];
        data_t cb [4];
        logic  co [4];
        data_t es [4];
        logic  ec [4];
        logic  ev [4];
        ca = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        cb = '{32'h1, 32'h1, 32'h1, 32'h1};
        co = '{1'b0, 1'b0, 1'b1, 1'b1};
        es = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1};
        ev = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            A = ca[i]; B = cb[i]; add_sub = co[i];
            #1;
            total++;
            if ({S, C, V} !== {es[i], ec[i], ev[i]}) begin
                bad++;
                $display("FAIL corner%0d got=%h/%b/%b exp=%h/%b/%b",
                         i, S, C, V, es[i], ec[i], ev[i]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk_i);
        A = 32'd1; B = 32'd1; add_sub = 1'b0;
        @(posedge clk_i);
        #1;
        total++;
        if (S_q !== 32'd2) begin
            bad++; $display("FAIL latency_initial got=%h exp=2", S_q);
        end
        @(negedge clk_i);
        A = 32'd2; B = 32'd2;
        #1;
        total++;
        if (S !== 32'd4 || S_q !== 32'd2) begin
            bad++; $display("FAIL latency_before_edge got S=%h S_q=%h exp S=4 S_q=2", S, S_q);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (S_q !== 32'd4) begin
            bad++; $display("FAIL latency_after_edge got=%h exp=4", S_q);
        end
    endtask

    task automatic test_back_to_back(input int n);
        data_t es;
        logic  ec, ev;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            A = $urandom(); B = $urandom(); add_sub = 1'($urandom_range(1));
            model(add_sub, A, B, es, ec, ev);
            // Mode toggled mid-cycle before the edge: only the last value counts.
            if ((i % 5) == 0) begin
                #2;
                add_sub = ~add_sub;
                model(add_sub, A, B, es, ec, ev);
            end
            @(posedge clk_i);
            #1;
            total++;
            if ({S_q, C_q, V_q} !== {es, ec, ev}) begin
                bad++;
                $display("FAIL back_to_back%0d got=%h/%b/%b exp=%h/%b/%b",
                         i, S_q, C_q, V_q, es, ec, ev);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_async_reset();
        test_random(1'b0, 1000);
        test_random(1'b1, 1000);
        test_corners();
        test_latency();
        test_back_to_back(60);
        if (bad == 0) $display("TEST PASSED");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_addsub_nbit

`default_nettype wire
